// File: rtl/aabb_slab_sequencer.sv
// aabb_slab_sequencer: serial Ray-AABB slab test driving one shared FP less-or-equal comparator
module aabb_slab_sequencer #(
    parameter int WIDTH   = 15,
    parameter int CMP_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [WIDTH:0] tnear_x_i,
    input  logic [WIDTH:0] tnear_y_i,
    input  logic [WIDTH:0] tnear_z_i,
    input  logic [WIDTH:0] tfar_x_i,
    input  logic [WIDTH:0] tfar_y_i,
    input  logic [WIDTH:0] tfar_z_i,
    input  logic           cmp_le_i,
    output logic [WIDTH:0] cmp_a_o,
    output logic [WIDTH:0] cmp_b_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           hit_o,
    output logic           err_o
);
    localparam logic [3:0] SAMPLE  = 4'(CMP_LAT - 1);
    localparam logic [3:0] ADVANCE = 4'(CMP_LAT);
    typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [5:0][WIDTH:0] op_q, op_d;
    logic [WIDTH:0] a_q, a_d, b_q, b_d, tmin_q, tmin_d, tmax_q, tmax_d, sel_a, sel_b;
    logic [2:0] step_q, step_d, nstep;
    logic [3:0] cnt_q, cnt_d;
    logic ok1_q, ok1_d, ok2_q, ok2_d, busy_q, busy_d, done_q, done_d, hit_q, hit_d, err_q, err_d, exn;
    always_comb begin
        exn = op_q[0][WIDTH] | op_q[1][WIDTH] | op_q[2][WIDTH] | op_q[3][WIDTH] | op_q[4][WIDTH] | op_q[5][WIDTH];
        nstep = (state_q == CHECK) ? 3'd0 : step_q + 3'd1;
        sel_a = (nstep == 3'd0) ? op_q[0] : (nstep == 3'd1) ? tmin_q : (nstep == 3'd2) ? op_q[3] :
                (nstep == 3'd3) ? tmax_q : (nstep == 3'd4) ? tmin_q : '0;
        sel_b = (nstep == 3'd0) ? op_q[1] : (nstep == 3'd1) ? op_q[2] : (nstep == 3'd2) ? op_q[4] :
                (nstep == 3'd3) ? op_q[5] : tmax_q;
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tmin_d  = tmin_q;
        tmax_d  = tmax_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        ok1_d   = ok1_q;
        ok2_d   = ok2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hit_d   = hit_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start_i) begin
                op_d    = {tfar_z_i, tfar_y_i, tfar_x_i, tnear_z_i, tnear_y_i, tnear_x_i};
                busy_d  = 1'b1;
                hit_d   = 1'b0;
                err_d   = 1'b0;
                state_d = CHECK;
            end
            CHECK: if (exn) begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                a_d     = sel_a;
                b_d     = sel_b;
                step_d  = 3'd0;
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: if (cnt_q == ADVANCE) begin
                if (step_q == 3'd5) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hit_d   = ok1_q & ok2_q;
                    state_d = DONE;
                end else begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    step_d = nstep;
                    cnt_d  = 4'd0;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
                // steps 0-1 keep the larger operand, steps 2-3 the smaller
                if (cnt_q == SAMPLE) begin
                    tmin_d = (step_q[2:1] == 2'b00) ? (cmp_le_i ? b_q : a_q) : tmin_q;
                    tmax_d = (step_q[2:1] == 2'b01) ? (cmp_le_i ? a_q : b_q) : tmax_q;
                    ok1_d  = (step_q == 3'd4) ? cmp_le_i : ok1_q;
                    ok2_d  = (step_q == 3'd5) ? cmp_le_i : ok2_q;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tmin_q  <= '0;
            tmax_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            ok1_q   <= 1'b0;
            ok2_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmin_q  <= tmin_d;
            tmax_q  <= tmax_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            ok1_q   <= ok1_d;
            ok2_q   <= ok2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end
    assign cmp_a_o = a_q;
    assign cmp_b_o = b_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign hit_o   = hit_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_aabb_slab_sequencer.sv
// tb_aabb_slab_sequencer: three latency variants driven in lockstep against an arithmetic slab-test model
module tb_aabb_slab_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] tnx = '0, tny = '0, tnz = '0, tfx = '0, tfy = '0, tfz = '0;
    logic [15:0] ca[3], cb[3];
    logic le[3], busy[3], done[3], hit[3], err[3];
    logic [15:0] last_a = '0, last_b = '0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;

    function automatic int key(input logic [15:0] v);
        int m;
        m = int'({19'd0, v[12:0]}) + 1;
        return (v[15:14] == 2'b00) ? 0 : (v[13] ? -m : m);
    endfunction
    function automatic logic kle(input logic [15:0] a, input logic [15:0] b);
        return key(a) <= key(b);
    endfunction
    function automatic logic [15:0] fp(input logic s, input logic [4:0] e, input logic [7:0] f);
        return {2'b01, s, e, f};
    endfunction
    function automatic int lat(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 7;
    endfunction
    function automatic logic [15:0] rnd(input logic exc);
        logic [31:0] u;
        int r;
        u = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h0000;
        if (exc && r == 1) return {1'b1, u[13:0], u[20]};
        return {2'b01, u[0], 5'($urandom_range(12, 18)), u[15:8]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 7;
        logic [15:0] p;
        aabb_slab_sequencer #(.WIDTH(15), .CMP_LAT(L)) dut (
            .clk(clk), .rst(rst), .start_i(start),
            .tnear_x_i(tnx), .tnear_y_i(tny), .tnear_z_i(tnz),
            .tfar_x_i(tfx), .tfar_y_i(tfy), .tfar_z_i(tfz),
            .cmp_le_i(le[g]), .cmp_a_o(ca[g]), .cmp_b_o(cb[g]),
            .busy_o(busy[g]), .done_o(done[g]), .hit_o(hit[g]), .err_o(err[g])
        );
        always @(posedge clk) p <= {p[14:0], kle(ca[g], cb[g])};
        assign le[g] = (L == 1) ? kle(ca[g], cb[g]) : p[(L > 1) ? L - 2 : 0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [15:0] nx, ny, nz, fx, fy, fz);
        logic [15:0] ea[6], eb[6], tmin, tmax;
        logic e_err, e_hit;
        int dn[3], dc[3];
        logic dh[3], de[3];
        ea[0] = nx; eb[0] = ny;
        tmin = (key(ny) >= key(nx)) ? ny : nx;
        ea[1] = tmin; eb[1] = nz;
        tmin = (key(nz) >= key(tmin)) ? nz : tmin;
        ea[2] = fx; eb[2] = fy;
        tmax = (key(fx) <= key(fy)) ? fx : fy;
        ea[3] = tmax; eb[3] = fz;
        tmax = (key(fz) < key(tmax)) ? fz : tmax;
        ea[4] = tmin; eb[4] = tmax;
        ea[5] = 16'h0000; eb[5] = tmax;
        e_err = nx[15] | ny[15] | nz[15] | fx[15] | fy[15] | fz[15];
        e_hit = !e_err && key(tmin) <= key(tmax) && key(tmax) >= 0;
        @(negedge clk);
        {tnx, tny, tnz, tfx, tfy, tfz} = {nx, ny, nz, fx, fy, fz};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        {tnx, tny, tnz} = {16'($urandom), 16'($urandom), 16'($urandom)};
        {tfx, tfy, tfz} = {16'($urandom), 16'($urandom), 16'($urandom)};
        for (int i = 0; i < 3; i++) begin
            chk("busy_accept", busy[i], 1'b1);
            dc[i] = 0; dn[i] = -1; dh[i] = 1'bx; de[i] = 1'bx;
        end
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 5 && !e_err) start = 1'b1;
            if (n == 6) start = 1'b0;
            for (int i = 0; i < 3; i++) if (done[i]) begin
                dc[i]++; dn[i] = n; dh[i] = hit[i]; de[i] = err[i];
            end
            if (!e_err && n <= 21 && (n - 1) % 4 == 0) begin
                chk("cmp_a_step", ca[0], ea[(n - 1) / 4]);
                chk("cmp_b_step", cb[0], eb[(n - 1) / 4]);
            end
            if (e_err && n == 1) for (int i = 0; i < 3; i++)
                chk("cmp_hold_err", {ca[i], cb[i]}, {last_a, last_b});
            if (n == 3) chk("busy_mid", busy[0], !e_err);
        end
        for (int i = 0; i < 3; i++) begin
            chk("done_count", dc[i], 1);
            chk("done_cycle", dn[i], e_err ? 1 : 1 + 6 * (lat(i) + 1));
            chk("hit_at_done", dh[i], e_hit);
            chk("err_at_done", de[i], e_err);
            chk("idle_after", busy[i], 1'b0);
            chk("hit_hold", {hit[i], err[i]}, {e_hit, e_err});
        end
        if (!e_err) begin
            last_a = 16'h0000;
            last_b = tmax;
        end
    endtask

    initial begin
        logic [15:0] p1, p2, p3, p4, p5, p05, m1, m2, m4, m5, m6, m05;
        int dcount;
        p05 = fp(0, 14, 0); p1 = fp(0, 15, 0); p2 = fp(0, 16, 0); p3 = fp(0, 16, 8'h80);
        p4 = fp(0, 17, 0); p5 = fp(0, 17, 8'h40);
        m05 = fp(1, 14, 0); m1 = fp(1, 15, 0); m2 = fp(1, 16, 0); m4 = fp(1, 17, 0);
        m5 = fp(1, 17, 8'h40); m6 = fp(1, 17, 8'h80);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("reset_values", {ca[i], cb[i], busy[i], done[i], hit[i], err[i]}, 36'd0);
        rst = 1'b0;
        run(p1, p2, p05, p4, p3, p5);
        run(p3, p1, p1, p2, p4, p4);
        run(m5, m4, m6, m1, m2, m05);
        run(p1, p2, p05, p4, 16'hC000, p5);
        @(negedge clk);
        {tnx, tny, tnz, tfx, tfy, tfz} = {p1, p2, p05, p4, p3, p5};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_abort", {ca[i], cb[i], busy[i], done[i], hit[i], err[i]}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) dcount += int'(done[i]);
        end
        chk("no_done_after_reset", dcount, 0);
        run(p1, p2, p05, p4, p3, p5);
        for (int k = 0; k < 14; k++)
            run(rnd(k[0]), rnd(k[0]), rnd(k[0]), rnd(k[0]), rnd(k[0]), rnd(k[0]));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aabb_slab_sequencer.md
Name: aabb_slab_sequencer

Overview:
- Control and datapath stage that wraps the shared FP less-or-equal comparator in the Ray-AABB slab test.
- Takes per-axis entry/exit parameters (tnear/tfar for x, y, z) and issues six operand pairs serially to a single comparator.
- Consumes the comparator's registered le bit after a fixed latency and reduces the results to tmin = max(tnear), tmax = min(tfar), then hit = (tmin <= tmax) && (0 <= tmax).
- Operands and results use the FloPoCo format: [W:W-1] exception (00 zero, 01 normal, 10 inf, 11 NaN), [W-2] sign, remainder exponent/fraction.

Parameters:
- WIDTH, 15, MSB index of an FP word; words are WIDTH+1 bits.
- CMP_LAT, 3, cycles from cmp_a/cmp_b changing at an edge to the edge at which cmp_le is valid to sample; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- tnear_x, tnear_y, tnear_z  in  WIDTH+1 each  slab entry parameters
- tfar_x, tfar_y, tfar_z  in  WIDTH+1 each  slab exit parameters
- cmp_a  out  WIDTH+1  comparator operand A (registered)
- cmp_b  out  WIDTH+1  comparator operand B (registered)
- cmp_le  in  1  comparator result, 1 when cmp_a <= cmp_b
- busy  out  1  high from the accept edge until done
- done  out  1  one-cycle pulse; hit/err valid from this cycle
- hit  out  1  ray intersects box
- err  out  1  an operand had exception 10 or 11

Behaviour:
- Reset values: cmp_a = 0, cmp_b = 0, busy = 0, done = 0, hit = 0, err = 0, FSM = IDLE, counters = 0. Reset mid-operation aborts the operation immediately with no done pulse.
- Accept: start = 1 in IDLE at edge E0. At E0, latch all six operands, set busy = 1, clear hit/err, enter CHECK. Start is ignored while busy.
- CHECK (1 cycle): if any latched operand has exn[1] = 1, go to DONE at E0+1 with err = 1, hit = 0, and issue no comparisons. Otherwise, at E0+1 load step-0 operands onto cmp_a/cmp_b and enter WAIT.
- Steps, with the operand pair as (A, B) and the action on sampled le:
  - step 0: (tnear_x, tnear_y); tmin = le ? tnear_y : tnear_x
  - step 1: (tmin, tnear_z); tmin = le ? tnear_z : tmin
  - step 2: (tfar_x, tfar_y); tmax = le ? tfar_x : tfar_y
  - step 3: (tmax, tfar_z); tmax = le ? tmax : tfar_z
  - step 4: (tmin, tmax); ok1 = le
  - step 5: (ZERO = all-zero word, tmax); ok2 = le
- Timing per step: operands change at edge S_k. A wait counter counts CMP_LAT cycles, and cmp_le is sampled at edge S_k+CMP_LAT. The next operands are driven at S_{k+1} = S_k+CMP_LAT+1. cmp_a/cmp_b hold steady for the whole step.
- S_0 = E0+1. After step 5 is sampled, the FSM enters DONE at edge E0+1+6*(CMP_LAT+1), which is E0+25 at the default.
- DONE (1 cycle): done = 1, busy = 0, hit = ok1 & ok2. Then return to IDLE. hit/err hold until the next accepted start.
- Ties select either operand; they are bit-identical for the comparison.
- cmp_a/cmp_b retain their last step values while in IDLE.
- FSM states: IDLE, CHECK, WAIT (with step index 0..5 and latency counter), DONE.
- Start is not accepted in the DONE cycle. The earliest re-accept is the cycle after done.

Test Plan:
- Bench uses a behavioural comparator model with CMP_LAT = 3 registered latency.
- Basic hit: tnear = (+1.0, +2.0, +0.5), tfar = (+4.0, +3.0, +5.0) -> tmin = +2.0, tmax = +3.0; done at E0+25, hit = 1, err = 0; cmp_a/cmp_b show the six pairs at E0+1, +5, +9, +13, +17, +21.
- Miss (tmin > tmax): tnear = (+3.0, +1.0, +1.0), tfar = (+2.0, +4.0, +4.0) -> hit = 0 at E0+25.
- Box behind ray: tnear = (-5.0, -4.0, -6.0), tfar = (-1.0, -2.0, -0.5) -> step 5 le = 0, hit = 0.
- NaN on tfar_y (exn 11) -> done at E0+1, err = 1, hit = 0, no change on cmp_a/cmp_b.
- Reset asserted at E0+10 -> all outputs 0 next cycle, no done. A start pulse during busy is ignored, and a new start after reset completes normally.
- Sweep CMP_LAT = 1 and 7 with the basic-hit vectors -> done at E0+13 and E0+49 respectively, hit = 1.
